svreal_accum: RTL and testbench

SVREAL_ACCUM -- requirements
Module: svreal_accum

---
 rtl/svreal_accum.sv | 188 ++++++++++++++++++
 tb/tb_svreal_accum.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/svreal_accum.sv
// svreal_accum -- block accumulator for a signed fixed-point product stream.
//
// Sums N consecutive accepted samples into a signed ACC_WIDTH accumulator.
// The block result is presented on out_value with a valid/ready handshake.
// out_value has the same binary exponent (IN_EXPONENT) as in_value.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   clear      synchronous abort of the current block (drops any offered sample)
//   in_value   signed IN_WIDTH input sample
//   in_valid   in_value is valid
//   in_ready   block accepts a sample this cycle (high in ACCUM)
//   out_value  signed ACC_WIDTH block sum
//   out_valid  out_value is valid (high in HOLD)
//   out_ready  downstream accepts out_value (ignored in ACCUM)
//   out_ovf    an overflow occurred while forming the current out_value
//
// Build option:
//   SVREAL_ACCUM_SAT_EN  defined: an overflowing step clamps the accumulator
//                        to the signed ACC_WIDTH range and accumulation
//                        continues from the clamped value.
//                        undefined: the accumulator wraps (two's complement).
//   out_ovf behaves the same in both builds.

module svreal_accum #(
  parameter int IN_WIDTH    = 18,
  parameter int IN_EXPONENT = -10,
  parameter int ACC_WIDTH   = 24,
  parameter int N           = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic signed [IN_WIDTH-1:0]  in_value,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [ACC_WIDTH-1:0] out_value,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_ovf
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // Configurations that cannot be built correctly stop elaboration; the
  // exponent bound keeps the value representable as a double on the model side.
  if (ACC_WIDTH < IN_WIDTH || N < 2 || IN_EXPONENT < -1022 || IN_EXPONENT > 1023) begin : g_bad_config
    $error("svreal_accum: unsupported parameter combination");
  end

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t                        state_q,     state_d;
  logic signed [ACC_WIDTH-1:0]   acc_q,       acc_d;
  logic [CW-1:0]                 cnt_q,       cnt_d;
  logic                          ovf_q,       ovf_d;
  logic signed [ACC_WIDTH-1:0]   out_value_q, out_value_d;
  logic                          out_valid_q, out_valid_d;
  logic                          out_ovf_q,   out_ovf_d;
  logic                          in_ready_q,  in_ready_d;

  logic signed [ACC_WIDTH-1:0]   in_ext_s;
  logic signed [ACC_WIDTH:0]     sum_wide_s;
  logic                          step_ovf_s;
  logic signed [ACC_WIDTH-1:0]   step_sum_s;
  logic                          accept_s;

  // One accumulation step: exact sum with one guard bit, overflow detect, wrap or clamp.
  always_comb begin
    in_ext_s   = ACC_WIDTH'(in_value);
    sum_wide_s = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(in_value);
    // Guard bit differs from the ACC_WIDTH sign bit exactly when the sum leaves the range.
    step_ovf_s = sum_wide_s[ACC_WIDTH] ^ sum_wide_s[ACC_WIDTH-1];
`ifdef SVREAL_ACCUM_SAT_EN
    if (step_ovf_s) begin
      step_sum_s = sum_wide_s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end else begin
      step_sum_s = sum_wide_s[ACC_WIDTH-1:0];
    end
`else
    step_sum_s = sum_wide_s[ACC_WIDTH-1:0];
`endif
    accept_s = in_valid && in_ready_q;
  end

  // Next-state logic for the ACCUM/HOLD block controller and its datapath.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_value_d = out_value_q;
    out_valid_d = out_valid_q;
    out_ovf_d   = out_ovf_q;
    in_ready_d  = in_ready_q;
    if (clear) begin
      // Abort wins over everything but rst; an offered sample is dropped.
      state_d     = ST_ACCUM;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (accept_s) begin
            if (cnt_q == '0) begin
              // Block start: load the sample and clear the sticky overflow.
              acc_d = in_ext_s;
              ovf_d = 1'b0;
              cnt_d = cnt_q + CW'(1);
            end else if (cnt_q == CNT_LAST) begin
              acc_d       = step_sum_s;
              ovf_d       = ovf_q | step_ovf_s;
              cnt_d       = '0;
              out_value_d = step_sum_s;
              out_ovf_d   = ovf_q | step_ovf_s;
              out_valid_d = 1'b1;
              in_ready_d  = 1'b0;
              state_d     = ST_HOLD;
            end else begin
              acc_d = step_sum_s;
              ovf_d = ovf_q | step_ovf_s;
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            state_d = ST_ACCUM;
          end
        end
        ST_HOLD: begin
          // in_ready stays low in the exit cycle, so no sample is taken then.
          if (out_ready) begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = ST_ACCUM;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d     = ST_ACCUM;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_value_q <= '0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_value_q <= out_value_d;
      out_valid_q <= out_valid_d;
      out_ovf_q   <= out_ovf_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_value = out_value_q;
  assign out_valid = out_valid_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_svreal_accum.sv
// Testbench for svreal_accum: scoreboarded default instance plus a narrow
// ACC_WIDTH=20, N=8 instance for the overflow case.
module tb_svreal_accum;

  localparam int IW  = 18;
  localparam int AW  = 24;
  localparam int NS  = 4;
  localparam int AW1 = 20;
  localparam int NS1 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, clear, in_valid, out_ready;
  logic signed [IW-1:0] in_value;
  logic                 in_ready, out_valid, out_ovf;
  logic signed [AW-1:0] out_value;

  logic                  clear_b, in_valid_b, out_ready_b;
  logic signed [IW-1:0]  in_value_b;
  logic                  in_ready_b, out_valid_b, out_ovf_b;
  logic signed [AW1-1:0] out_value_b;

  svreal_accum #(.IN_WIDTH(IW), .IN_EXPONENT(-10), .ACC_WIDTH(AW), .N(NS)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_value(in_value), .in_valid(in_valid), .in_ready(in_ready),
    .out_value(out_value), .out_valid(out_valid), .out_ready(out_ready),
    .out_ovf(out_ovf)
  );

  svreal_accum #(.IN_WIDTH(IW), .IN_EXPONENT(-10), .ACC_WIDTH(AW1), .N(NS1)) dut_b (
    .clk(clk), .rst(rst), .clear(clear_b),
    .in_value(in_value_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out_value(out_value_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_ovf(out_ovf_b)
  );

  typedef struct {
    longint value;
    logic   ovf;
  } exp_t;

  exp_t   exp_q[$];
  longint blk_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic check_eq(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference block sum for the default instance, using wide integer arithmetic.
  function automatic exp_t model_block();
    exp_t   r;
    longint mx = (64'sd1 <<< (AW - 1)) - 64'sd1;
    longint mn = -(64'sd1 <<< (AW - 1));
    longint acc = blk_q[0];
    longint sum;
    r.ovf = 1'b0;
    for (int i = 1; i < blk_q.size(); i++) begin
      sum = acc + blk_q[i];
      if (sum > mx || sum < mn) begin
        r.ovf = 1'b1;
`ifdef SVREAL_ACCUM_SAT_EN
        acc = (sum > mx) ? mx : mn;
`else
        acc = (sum > mx) ? sum - (mx - mn + 64'sd1) : sum + (mx - mn + 64'sd1);
`endif
      end else begin
        acc = sum;
      end
    end
    r.value = acc;
    return r;
  endfunction

  // Offer one sample to the default instance until accepted (bounded).
  task automatic send(input longint v);
    bit ok = 1'b0;
    in_value = v[IW-1:0];
    in_valid = 1'b1;
    for (int g = 0; g < 40 && !ok; g++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check_eq("send_accept", ok, 1);
    if (ok) begin
      blk_q.push_back(v);
      if (blk_q.size() == NS) begin
        exp_q.push_back(model_block());
        blk_q.delete();
      end
    end
  endtask

  task automatic send_b(input longint v);
    bit ok = 1'b0;
    in_value_b = v[IW-1:0];
    in_valid_b = 1'b1;
    for (int g = 0; g < 40 && !ok; g++) begin
      @(negedge clk);
      ok = in_ready_b;
      @(posedge clk);
      #1;
    end
    in_valid_b = 1'b0;
    check_eq("send_b_accept", ok, 1);
  endtask

  // Scoreboard: every completed handshake on the default instance pops one result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_result", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check_eq("out_value", out_value, e.value);
        check_eq("out_ovf", out_ovf, e.ovf);
      end
    end
  end

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_value = '0; out_ready = 1'b1;
    clear_b = 1'b0; in_valid_b = 1'b0; in_value_b = '0; out_ready_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_value", out_value, 0);
    check_eq("rst_out_ovf", out_ovf, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Four samples of 1.0 -> 4.0, one-cycle latency, valid for one cycle.
    for (int i = 0; i < 3; i++) send(1024);
    check_eq("valid_before_last", out_valid, 0);
    send(1024);
    check_eq("latency_valid", out_valid, 1);
    check_eq("latency_value", out_value, 4096);
    @(posedge clk);
    #1;
    check_eq("valid_one_cycle", out_valid, 0);
    check_eq("ready_after_hs", in_ready, 1);

    // Gapped samples with downstream stalled for five cycles.
    out_ready = 1'b0;
    send(1024);
    repeat (2) begin @(posedge clk); #1; end
    send(-3072);
    @(posedge clk); #1;
    send(512);
    repeat (3) begin @(posedge clk); #1; end
    send(256);
    for (int i = 0; i < 5; i++) begin
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_in_ready", in_ready, 0);
      check_eq("hold_value", out_value, -1280);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("hold_released", out_valid, 0);
    send(5); send(-9); send(300); send(-1);

    // Clear with a sample offered in the same cycle: sample is dropped.
    send(50); send(60);
    clear = 1'b1; in_valid = 1'b1; in_value = 18'sd999;
    @(posedge clk);
    #1;
    clear = 1'b0; in_valid = 1'b0;
    blk_q.delete();
    check_eq("clear_in_ready", in_ready, 1);
    check_eq("clear_out_valid", out_valid, 0);
    for (int i = 0; i < 4; i++) send(100);
    @(posedge clk);
    #1;

    // Asynchronous reset between edges while holding a result.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(3);
    @(posedge clk);
    #2;
    check_eq("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check_eq("async_rst_valid", out_valid, 0);
    check_eq("async_rst_ready", in_ready, 1);
    check_eq("async_rst_value", out_value, 0);
    exp_q.delete();
    blk_q.delete();
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send(1);
    @(posedge clk);
    #1;

    // Narrow accumulator overflow: eight samples of 131071.
    for (int i = 0; i < NS1; i++) send_b(131071);
    check_eq("ovf_valid", out_valid_b, 1);
    check_eq("ovf_flag", out_ovf_b, 1);
`ifdef SVREAL_ACCUM_SAT_EN
    check_eq("ovf_value", out_value_b, 524287);
`else
    check_eq("ovf_value", out_value_b, -8);
`endif

    repeat (3) begin @(posedge clk); #1; end
    check_eq("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
